// File: rtl/simon_pkg.sv
// simon_pkg: packet format constants, parser state encoding and error indices shared by both packet ends
package simon_pkg;
   localparam int MODE_LSB   = 0;
   localparam int MODE_MSB   = 3;
   localparam int INFO_INPUT = 4;
   localparam int INFO_KEY   = 5;
   localparam int INFO_DUAL  = 7;
   localparam int ERR_COUNT  = 0;
   localparam int ERR_MODE   = 1;
   localparam int ERR_TYPE   = 2;
   typedef enum logic [2:0] {IDLE, CHECK, PRESENT, RELEASE, ACK} state_t;
endpackage

// File: rtl/simon_pkt_check.sv
// simon_pkt_check: combinational mode/type/count validation of a received packet header
module simon_pkt_check
   import simon_pkg::*;
#(
   parameter logic [3:0] MODE = 4'd0
) (
   input  logic [7:0] info,
   input  logic [7:0] count,
   input  logic [7:0] expected,
   output logic [2:0] err,
   output logic       drop
);
   assign err[ERR_COUNT] = count != expected;
   assign err[ERR_MODE]  = info[MODE_MSB:MODE_LSB] != MODE;
   assign err[ERR_TYPE]  = !info[INFO_INPUT];
   // a count mismatch is reported but the packet is still delivered
   assign drop = err[ERR_MODE] | err[ERR_TYPE];
endmodule

// File: rtl/simon_pkt_in.sv
// simon_pkt_in: receive-side packet parser feeding keys or blocks to the SIMON core
// over a four-phase handshake, with host backpressure through readIN.
module simon_pkt_in
   import simon_pkg::*;
#(
   parameter int N    = 16,
   parameter int M    = 4,
   parameter int MODE = 0
) (
   input  logic                   clk,
   input  logic                   nR,
   input  logic                   newIN,
   input  logic [(2+N/2)*8-1:0]   in,
   output logic                   readIN,
   input  logic                   readData,
   output logic                   doneData,
   output logic [7:0]             infoIN,
   output logic [7:0]             countIN,
   output logic [2*N-1:0]         blockIN,
   output logic [M*N-1:0]         keyIN,
   output logic [2:0]             err
);
   localparam int DW = 4*N;

   state_t              state;
   logic [DW+15:0]      pkt;
   logic [7:0]          expected;
   logic                second;
   logic [7:0]          info;
   logic [7:0]          count;
   logic [DW-1:0]       data;
   logic [2:0]          chk_err;
   logic                drop;

   assign info  = pkt[DW+8 +: 8];
   assign count = pkt[DW +: 8];
   assign data  = pkt[DW-1:0];

   simon_pkt_check #(.MODE(4'(MODE))) u_check (
      .info(info),
      .count(count),
      .expected(expected),
      .err(chk_err),
      .drop(drop)
   );

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         state    <= IDLE;
         pkt      <= '0;
         expected <= '0;
         second   <= 1'b0;
         readIN   <= 1'b0;
         doneData <= 1'b0;
         infoIN   <= '0;
         countIN  <= '0;
         blockIN  <= '0;
         keyIN    <= '0;
         err      <= '0;
      end else begin
         case (state)
            IDLE: if (newIN && !readIN) begin
               pkt    <= in;
               readIN <= 1'b1;
               state  <= CHECK;
            end
            CHECK: begin
               // match advances by one, mismatch resyncs to count+1: same value either way
               expected <= count + 8'd1;
               err      <= err | chk_err;
               second   <= 1'b0;
               if (drop) state <= ACK;
               else begin
                  infoIN   <= info;
                  countIN  <= count;
                  if (info[INFO_KEY]) keyIN <= data[M*N-1:0];
                  else blockIN <= data[2*N-1:0];
                  doneData <= 1'b1;
                  state    <= PRESENT;
               end
            end
            PRESENT: if (readData) begin
               doneData <= 1'b0;
               state    <= RELEASE;
            end
            RELEASE: if (!readData) begin
               if (info[INFO_DUAL] && !info[INFO_KEY] && !second) begin
                  blockIN  <= data[4*N-1:2*N];
                  doneData <= 1'b1;
                  second   <= 1'b1;
                  state    <= PRESENT;
               end else state <= ACK;
            end
            ACK: if (!newIN) begin
               readIN <= 1'b0;
               second <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_simon_pkt_in.sv
// tb_simon_pkt_in: directed self-checking bench for the SIMON input packet parser
module tb_simon_pkt_in;
   localparam int N = 16;
   localparam int M = 4;
   localparam logic [63:0] DATA = 64'h8877_6655_4433_2211;

   logic          clk = 1'b0;
   logic          nR = 1'b0;
   logic          newIN = 1'b0;
   logic          readData = 1'b0;
   logic [79:0]   in_pkt = '0;
   logic          readIN, doneData;
   logic [7:0]    infoIN, countIN;
   logic [31:0]   blockIN;
   logic [63:0]   keyIN;
   logic [2:0]    err;
   int            n_chk = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   simon_pkt_in #(.N(N), .M(M), .MODE(0)) dut (
      .clk(clk), .nR(nR), .newIN(newIN), .in(in_pkt), .readIN(readIN),
      .readData(readData), .doneData(doneData), .infoIN(infoIN),
      .countIN(countIN), .blockIN(blockIN), .keyIN(keyIN), .err(err)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sends one packet and completes nblk core handshakes, then the host release
   task automatic run_pkt(input logic [7:0] info, input logic [7:0] cnt, input int nblk,
                          input logic [31:0] b0, input logic [31:0] b1);
      in_pkt = {info, cnt, DATA};
      newIN = 1'b1;
      step;
      chk("readIN_rise", readIN, 1'b1);
      chk("done_early", doneData, 1'b0);
      for (int b = 0; b < nblk; b++) begin
         if (b == 0) step;
         else for (int i = 0; i < 8 && doneData !== 1'b1; i++) step;
         chk("done_rise", doneData, 1'b1);
         chk("block", blockIN, b == 0 ? b0 : b1);
         chk("info", infoIN, info);
         chk("count", countIN, cnt);
         readData = 1'b1;
         step;
         chk("done_fall", doneData, 1'b0);
         step;
         step;
         chk("done_held_low", doneData, 1'b0);
         readData = 1'b0;
      end
      repeat (4) step;
      chk("no_extra_done", doneData, 1'b0);
      chk("readIN_hold", readIN, 1'b1);
      newIN = 1'b0;
      step;
      chk("readIN_fall", readIN, 1'b0);
   endtask

   initial begin
      #1;
      chk("rst_readIN", readIN, 1'b0);
      chk("rst_done", doneData, 1'b0);
      chk("rst_block", blockIN, 32'h0);
      chk("rst_key", keyIN, 64'h0);
      chk("rst_err", err, 3'b000);
      step;
      nR = 1'b1;
      step;
      run_pkt(8'h10, 8'h00, 1, 32'h4433_2211, 32'h0);
      chk("err_t1", err, 3'b000);
      run_pkt(8'h90, 8'h01, 2, 32'h4433_2211, 32'h8877_6655);
      chk("err_t2", err, 3'b000);
      run_pkt(8'hB0, 8'h02, 1, 32'h8877_6655, 32'h0);
      chk("key", keyIN, 64'h8877_6655_4433_2211);
      chk("err_t3", err, 3'b000);
      run_pkt(8'h11, 8'h03, 0, 32'h0, 32'h0);
      chk("err_mode", err, 3'b010);
      run_pkt(8'h00, 8'h04, 0, 32'h0, 32'h0);
      chk("err_type", err, 3'b110);
      run_pkt(8'h10, 8'h05, 1, 32'h4433_2211, 32'h0);
      chk("count_after_drop", err, 3'b110);
      run_pkt(8'h10, 8'h08, 1, 32'h4433_2211, 32'h0);
      chk("err_count", err, 3'b111);
      run_pkt(8'h10, 8'h09, 1, 32'h4433_2211, 32'h0);
      chk("err_resync", err, 3'b111);
      in_pkt = {8'h10, 8'h00, DATA};
      newIN = 1'b1;
      step;
      step;
      chk("mid_done", doneData, 1'b1);
      nR = 1'b0;
      #1;
      chk("mr_readIN", readIN, 1'b0);
      chk("mr_done", doneData, 1'b0);
      chk("mr_info", infoIN, 8'h00);
      chk("mr_count", countIN, 8'h00);
      chk("mr_block", blockIN, 32'h0);
      chk("mr_key", keyIN, 64'h0);
      chk("mr_err", err, 3'b000);
      newIN = 1'b0;
      step;
      nR = 1'b1;
      step;
      run_pkt(8'h10, 8'h00, 1, 32'h4433_2211, 32'h0);
      chk("post_rst_err", err, 3'b000);
      for (int c = 1; c < 256; c++) run_pkt(8'h10, 8'(c), 1, 32'h4433_2211, 32'h0);
      chk("err_at_ff", err, 3'b000);
      run_pkt(8'h10, 8'h00, 1, 32'h4433_2211, 32'h0);
      chk("err_wrap", err, 3'b000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/simon_pkt_in.md
# simon_pkt_in

Input packet parser for the SIMON datapath, the receive-side counterpart of the output packet builder. It accepts one (2+N/2)-byte packet from the host-facing interface: info byte, count byte, then 4 N-bit data words. It checks mode, type and sequence count, then hands either a key (M words) or one or two N-bit-pair blocks to the cipher core over a four-phase handshake. It sits between the host byte interface and the SIMON round core.

## Interface
- N, 16, cipher word width in bits (block = 2 words).
- M, 4, key words (M ≤ 4).
- MODE, 0, expected value of info[3:0].
- clk  in  1  clock, rising edge.
- nR  in  1  asynchronous active-low reset.
- newIN  in  1  upstream packet valid; held until readIN seen high.
- in  in  (2+N/2)×8  packet; byte [1+N/2] = info, byte [N/2] = count, bytes [N/2-1:0] = data words 3..0 (word i = flat bits [i·N +: N]).
- readIN  out  1  packet accepted; held high until packet fully processed and newIN low.
- readData  in  1  core has taken the presented item.
- doneData  out  1  item valid on infoIN/countIN/blockIN/keyIN.
- infoIN  out  8  info byte of current packet.
- countIN  out  8  count byte of current packet.
- blockIN  out  2×N  block; [0] = even word, [1] = odd word.
- keyIN  out  M×N  key words 0..M-1.
- err  out  3  sticky flags: [0] count mismatch, [1] mode mismatch, [2] not an input packet.

## Operation
- Info decode: [3:0] mode, [4] input-packet flag (must be 1), [5] key packet, [7] two-block packet. A key packet ignores [7].
- States: IDLE, CHECK, PRESENT, RELEASE, ACK.
- IDLE: on newIN=1 and readIN=0, register `in`, set readIN=1, go CHECK.
- CHECK:
  - count ≠ expected → err[0]=1. The packet is still processed, and the expected count resyncs to count+1.
  - count = expected → expected+1, mod 256 (0xFF wraps to 0x00).
  - info[3:0] ≠ MODE → err[1]=1. info[4]=0 → err[2]=1. Either of these drops the packet: go ACK, no core handshake.
  - Otherwise load infoIN and countIN. If key packet, load keyIN = words M-1..0 and leave blockIN unchanged. Else blockIN = {word1, word0}. Set doneData=1, go PRESENT.
- PRESENT: wait for readData=1, then doneData=0, go RELEASE.
- RELEASE: wait for readData=0.
  - Two-block packet with first block done: blockIN = {word3, word2}, doneData=1, mark second, go PRESENT.
  - Otherwise go ACK.
- ACK: wait for newIN=0, then readIN=0, clear second, go IDLE.
- err bits clear only on reset.

## Timing
- Reset: readIN=0, doneData=0, infoIN=0, countIN=0, blockIN=0, keyIN=0, err=0, expected count=0, state IDLE. Applies immediately and mid-packet; a partially delivered packet is discarded.
- newIN first sampled high at edge k:
  - readIN rises after edge k.
  - doneData rises after edge k+1.
  - Dropped packets keep doneData low.
- Core handshake is four-phase:
  - doneData falls the edge after readData is sampled high.
  - The next doneData rises no earlier than the edge after readData is sampled low.
  - Outputs are stable while doneData=1.
- readIN falls the edge after newIN is sampled low in ACK, and never before the last core handshake completes. This provides host backpressure.
- If newIN drops early (before ACK), readIN still holds until processing ends.
- newIN high while readIN high is ignored. A new packet is accepted only from IDLE.

## Structure
- Shared package `simon_pkg`:
  - info bit-position constants (MODE_LSB/MSB, INFO_INPUT=4, INFO_KEY=5, INFO_DUAL=7);
  - state enum;
  - error-index constants.
- The same package is used by the output builder so both ends agree on format.
- One natural sub-module: `simon_pkt_check`. It is combinational: mode/type/count comparison producing error flags and a drop flag.

## Test plan
All with N=16, M=4, MODE=0; data bytes give word0=0x2211, word1=0x4433, word2=0x6655, word3=0x8877.
- info=0x10, count=0x00 → one doneData, blockIN={0x4433,0x2211}, err=0, readIN falls after newIN drops.
- info=0x90, count=0x01 → two handshakes: {0x4433,0x2211} then {0x8877,0x6655}; no doneData between handshakes until readData low.
- info=0xB0, count=0x02 → single handshake, keyIN={0x8877,0x6655,0x4433,0x2211}, blockIN unchanged.
- info=0x11 or 0x00 → err[1] or err[2] set, no doneData, readIN handshake completes, expected count still advances.
- count=0x05 when 0x03 expected → err[0]=1, block delivered, next count 0x06 raises no new error. Also check 0xFF→0x00 wrap is clean.
- nR low while in PRESENT → all outputs 0 immediately; next packet with count=0x00 is accepted with no error.
